// File: rtl/rob_retire_ctrl_if.sv
// rob_retire_ctrl_if: allocation, completion, retire and flush signals of the reorder-buffer controller
interface rob_retire_ctrl_if #(parameter int SIZE = 8, parameter int RETIRE_WIDTH = 2);
  localparam int TW = $clog2(SIZE);
  logic alloc_valid;
  logic alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic complete_valid;
  logic [TW-1:0] complete_tag;
  logic [RETIRE_WIDTH-1:0] retire_valid;
  logic [RETIRE_WIDTH*TW-1:0] retire_tag;
  logic retire_ready;
  logic flush_change;
  logic [TW-1:0] flush_front_ptr;
  logic [TW-1:0] front_ptr;
  logic [TW-1:0] back_ptr;
  logic [SIZE-1:0] valid_o;
  logic [TW:0] count;
  modport master (
    output alloc_valid, complete_valid, complete_tag, retire_ready, flush_change, flush_front_ptr,
    input alloc_ready, alloc_tag, retire_valid, retire_tag, front_ptr, back_ptr, valid_o, count
  );
  modport slave (
    input alloc_valid, complete_valid, complete_tag, retire_ready, flush_change, flush_front_ptr,
    output alloc_ready, alloc_tag, retire_valid, retire_tag, front_ptr, back_ptr, valid_o, count
  );
endinterface

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: reorder-buffer occupancy, in-order retirement and flush rollback
module rob_retire_ctrl #(
  parameter int SIZE = 8,
  parameter int RETIRE_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  rob_retire_ctrl_if.slave bus
);
  localparam int TW = $clog2(SIZE);
  logic [SIZE-1:0] valid, done, valid_n, done_n;
  logic [TW-1:0] front, back, idx, off, span;
  logic [TW:0] cnt, cnt_n, n, nr;
  logic [RETIRE_WIDTH-1:0] rv;
  logic alloc_fire, run;
  assign bus.alloc_ready = (cnt != (TW+1)'(SIZE)) && !bus.flush_change;
  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
  assign bus.alloc_tag = front;
  assign bus.front_ptr = front;
  assign bus.back_ptr = back;
  assign bus.valid_o = valid;
  assign bus.count = cnt;
  assign bus.retire_valid = rv;
  assign nr = bus.retire_ready ? n : '0;
  genvar g;
  generate
    for (g = 0; g < RETIRE_WIDTH; g++) begin : g_tag
      assign bus.retire_tag[g*TW +: TW] = back + TW'(g);
    end
  endgenerate
  always_comb begin
    rv = '0;
    n = '0;
    idx = '0;
    run = !bus.flush_change;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      idx = back + TW'(k);
      run = run && valid[idx] && done[idx];
      rv[k] = run;
      n = n + (TW+1)'(run);
    end
  end
  always_comb begin
    valid_n = valid;
    done_n = done;
    off = '0;
    span = front - bus.flush_front_ptr;
    if (bus.complete_valid && valid[bus.complete_tag]) done_n[bus.complete_tag] = 1'b1;
    if (bus.retire_ready)
      for (int k = 0; k < RETIRE_WIDTH; k++)
        if (rv[k]) begin
          valid_n[back + TW'(k)] = 1'b0;
          done_n[back + TW'(k)] = 1'b0;
        end
    if (alloc_fire) begin
      valid_n[front] = 1'b1;
      done_n[front] = 1'b0;
    end
    if (bus.flush_change)
      for (int i = 0; i < SIZE; i++) begin
        off = TW'(i) - bus.flush_front_ptr;
        if (off < span) begin
          valid_n[i] = 1'b0;
          done_n[i] = 1'b0;
        end
      end
  end
  always_comb begin
    cnt_n = cnt + (TW+1)'(alloc_fire) - nr;
    if (bus.flush_change)
      cnt_n = (bus.flush_front_ptr == front && cnt[TW]) ? cnt : {1'b0, bus.flush_front_ptr - back};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      done <= '0;
      front <= '0;
      back <= '0;
      cnt <= '0;
    end else begin
      valid <= valid_n;
      done <= done_n;
      front <= bus.flush_change ? bus.flush_front_ptr : front + TW'(alloc_fire);
      back <= back + TW'(nr);
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// tb_rob_retire_ctrl: directed stimulus checked against a queue-based occupancy model and literal expectations
module tb_rob_retire_ctrl;
  localparam int SIZE = 8;
  localparam int RW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int mq[$];
  bit md[SIZE];
  int mb = 0;
  int m_ef, m_nc, m_n, m_t;
  logic [SIZE-1:0] m_ev;
  logic [RW-1:0] m_rv;
  logic [RW*3-1:0] m_rt;
  logic m_ar, m_run;
  rob_retire_ctrl_if #(.SIZE(SIZE), .RETIRE_WIDTH(RW)) bus();
  rob_retire_ctrl #(.SIZE(SIZE), .RETIRE_WIDTH(RW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mb = 0;
      for (int i = 0; i < SIZE; i++) md[i] = 0;
    end else begin
      m_ef = (mb + mq.size()) % SIZE;
      m_ev = '0;
      foreach (mq[i]) m_ev[mq[i]] = 1'b1;
      m_ar = (mq.size() < SIZE) && !bus.flush_change;
      m_rv = '0;
      m_n = 0;
      m_run = !bus.flush_change;
      for (int k = 0; k < RW; k++) begin
        m_rt[k*3 +: 3] = 3'((mb + k) % SIZE);
        if (m_run && k < mq.size() && md[mq[k]]) begin
          m_rv[k] = 1'b1;
          m_n++;
        end else m_run = 1'b0;
      end
      chk("model alloc_ready", bus.alloc_ready, m_ar);
      chk("model alloc_tag", bus.alloc_tag, m_ef);
      chk("model front_ptr", bus.front_ptr, m_ef);
      chk("model back_ptr", bus.back_ptr, mb);
      chk("model count", bus.count, mq.size());
      chk("model valid_o", bus.valid_o, m_ev);
      chk("model retire_valid", bus.retire_valid, m_rv);
      chk("model retire_tag", bus.retire_tag, m_rt);
      if (bus.complete_valid && m_ev[bus.complete_tag]) md[bus.complete_tag] = 1;
      if (bus.flush_change) begin
        m_nc = (int'(bus.flush_front_ptr) == m_ef) ? mq.size() : (int'(bus.flush_front_ptr) - mb + SIZE) % SIZE;
        while (mq.size() > m_nc) begin
          m_t = mq.pop_back();
          md[m_t] = 0;
        end
      end else begin
        if (bus.retire_ready)
          repeat (m_n) begin
            m_t = mq.pop_front();
            md[m_t] = 0;
            mb = (mb + 1) % SIZE;
          end
        if (bus.alloc_valid && m_ar) begin
          mq.push_back(m_ef);
          md[m_ef] = 0;
        end
      end
    end
  end
  task automatic set_in(input logic av, input logic cv, input logic [2:0] ct, input logic rr, input logic fl, input logic [2:0] ffp);
    bus.alloc_valid = av;
    bus.complete_valid = cv;
    bus.complete_tag = ct;
    bus.retire_ready = rr;
    bus.flush_change = fl;
    bus.flush_front_ptr = ffp;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    step;
    step;
    rst = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end
  initial begin
    do_reset;
    #1;
    chk("reset count", bus.count, 0);
    chk("reset alloc_ready", bus.alloc_ready, 1);
    chk("reset retire_valid", bus.retire_valid, 0);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      #1;
      chk("fill alloc_tag", bus.alloc_tag, i);
      step;
    end
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk("full alloc_ready", bus.alloc_ready, 0);
    chk("full count", bus.count, 8);
    chk("full front_ptr", bus.front_ptr, 0);
    chk("full back_ptr", bus.back_ptr, 0);
    step;
    set_in(0, 1, 1, 0, 0, 0);
    step;
    set_in(0, 1, 0, 0, 0, 0);
    step;
    set_in(1, 0, 0, 1, 0, 0);
    #1;
    chk("full+retire retire_valid", bus.retire_valid, 2'b11);
    chk("full+retire alloc_ready", bus.alloc_ready, 0);
    step;
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk("after retire count", bus.count, 6);
    chk("after retire back_ptr", bus.back_ptr, 2);
    chk("after retire alloc_tag", bus.alloc_tag, 0);
    step;
    set_in(1, 0, 0, 0, 0, 0);
    step;
    set_in(0, 0, 0, 0, 1, 2);
    #1;
    chk("flush same-front alloc_ready", bus.alloc_ready, 0);
    chk("flush same-front pre count", bus.count, 8);
    step;
    set_in(0, 0, 0, 0, 1, 4);
    #1;
    chk("flush same-front count", bus.count, 8);
    chk("flush same-front valid_o", bus.valid_o, 8'hff);
    step;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("partial flush count", bus.count, 2);
    chk("partial flush front_ptr", bus.front_ptr, 4);
    chk("partial flush valid_o", bus.valid_o, 8'h0c);
    do_reset;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      step;
    end
    set_in(0, 1, 1, 1, 0, 0);
    #1;
    chk("ooo none ready", bus.retire_valid, 0);
    step;
    set_in(0, 1, 0, 1, 0, 0);
    #1;
    chk("ooo tag1 done only", bus.retire_valid, 0);
    step;
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("retire pair valid", bus.retire_valid, 2'b11);
    chk("retire pair tags", bus.retire_tag, 6'b001_000);
    step;
    set_in(0, 1, 3, 1, 0, 0);
    #1;
    chk("post retire back_ptr", bus.back_ptr, 2);
    chk("post retire count", bus.count, 2);
    chk("post retire retire_valid", bus.retire_valid, 0);
    step;
    set_in(0, 1, 2, 1, 0, 0);
    #1;
    chk("gap blocks retire", bus.retire_valid, 0);
    step;
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("gap filled valid", bus.retire_valid, 2'b11);
    chk("gap filled tags", bus.retire_tag, 6'b011_010);
    step;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("drained count", bus.count, 0);
    chk("drained back_ptr", bus.back_ptr, 4);
    for (int i = 0; i < 6; i++) begin
      set_in(1, 0, 0, 0, 0, 0);
      step;
    end
    for (int t = 4; t < 7; t++) begin
      set_in(0, 1, 3'(t), 0, 0, 0);
      step;
    end
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("wrap retire valid", bus.retire_valid, 2'b11);
    step;
    set_in(1, 1, 0, 1, 1, 7);
    #1;
    chk("wrap back_ptr", bus.back_ptr, 6);
    chk("wrap front_ptr", bus.front_ptr, 2);
    chk("wrap count", bus.count, 4);
    chk("flush cycle alloc_ready", bus.alloc_ready, 0);
    chk("flush cycle retire_valid", bus.retire_valid, 0);
    step;
    set_in(0, 1, 3, 0, 0, 0);
    #1;
    chk("wrap flush front_ptr", bus.front_ptr, 7);
    chk("wrap flush count", bus.count, 1);
    chk("wrap flush valid_o", bus.valid_o, 8'h40);
    chk("wrap flush retire_valid", bus.retire_valid, 2'b01);
    step;
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("stray completion count", bus.count, 1);
    chk("stray completion valid_o", bus.valid_o, 8'h40);
    step;
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk("wrap alloc tag 7", bus.alloc_tag, 7);
    step;
    set_in(1, 0, 0, 0, 0, 0);
    #1;
    chk("wrap alloc tag 0", bus.alloc_tag, 0);
    step;
    set_in(0, 0, 0, 1, 0, 0);
    #1;
    chk("reused tag not done", bus.retire_valid, 0);
    chk("reused count", bus.count, 2);
    step;
    set_in(0, 0, 0, 0, 1, 7);
    step;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush to back count", bus.count, 0);
    chk("flush to back valid_o", bus.valid_o, 0);
    chk("flush to back alloc_ready", bus.alloc_ready, 1);
    step;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
